fft_bfly_s2: RTL and testbench

Radix-2 butterfly with twiddle multiply for the streaming FFT datapath. Sits directly downstream of the stage-1 reorder block: consumes its reordered pair stream (`s1_en`, `idx`, two complex samples), multiplies the second sample by the twiddle W_N^idx, and emits sum/difference. Fully pipelined, one butterfly per enabled cycle, fixed 4-cycle latency.

---
 rtl/fft_bfly_s2_pkg.sv | 25 ++
 rtl/fft_twiddle_rom.sv | 49 ++++
 rtl/fft_bfly_s2.sv | 136 +++++++++++++
 tb/tb_fft_bfly_s2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bfly_s2_pkg.sv
// Shared constants and helpers for the stage-2 radix-2 butterfly.
// W is the sample width, TF the twiddle fraction bits (1.0 == 2**TF).
package fft_bfly_s2_pkg;

    localparam int W   = 16;
    localparam int TF  = W - 2;
    localparam int RND = 1 << (TF - 1);

    localparam logic signed [W+1:0] SAT_HI = (W+2)'((2 ** (W - 1)) - 1);
    localparam logic signed [W+1:0] SAT_LO = ~SAT_HI;

    // Clamp a (W+2)-bit signed value into the W-bit signed range.
    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
        logic signed [W-1:0] r;
        if (v > SAT_HI) begin
            r = SAT_HI[W-1:0];
        end else if (v < SAT_LO) begin
            r = SAT_LO[W-1:0];
        end else begin
            r = v[W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle ROM: W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) in Q(TF),
// rounded to nearest. The table is built at elaboration and read
// through a registered output.
module fft_twiddle_rom
    import fft_bfly_s2_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [$clog2(N)-2:0]   k,
    output logic signed [W-1:0]    wr,
    output logic signed [W-1:0]    wi
);

    localparam real PI  = 3.14159265358979323846;
    localparam real ONE = real'(1 << TF);

    // Packs N/2 rounded twiddle parts; imag selects -sin instead of cos.
    function automatic logic [N/2*W-1:0] build_tab(input bit imag);
        logic [N/2*W-1:0] t;
        real ang;
        real v;
        int  q;
        t = '0;
        for (int i = 0; i < N / 2; i++) begin
            ang = 2.0 * PI * real'(i) / real'(N);
            v   = imag ? -$sin(ang) : $cos(ang);
            q   = $rtoi($floor(v * ONE + 0.5));
            t[i*W +: W] = q[W-1:0];
        end
        return t;
    endfunction

    localparam logic [N/2*W-1:0] TAB_RE = build_tab(1'b0);
    localparam logic [N/2*W-1:0] TAB_IM = build_tab(1'b1);

    // Registered lookup so the twiddle lines up with the P1 data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            wi <= '0;
        end else begin
            wr <= TAB_RE[k*W +: W];
            wi <= TAB_IM[k*W +: W];
        end
    end

endmodule

// File: rtl/fft_bfly_s2.sv
// Stage-2 radix-2 butterfly with twiddle multiply, 4-stage pipeline:
// P1 input/twiddle registers, P2 products, P3 rounded twiddle product,
// P4 sum/difference with saturation.
// Optional build macro: FFT_BFLY_SCALE_EN halves (floor) both outputs
// before saturation so cascaded stages cannot overflow.
module fft_bfly_s2
    import fft_bfly_s2_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s1_en,
    input  logic [$clog2(N)-2:0]   idx,
    input  logic signed [W-1:0]    ar,
    input  logic signed [W-1:0]    ai,
    input  logic signed [W-1:0]    br,
    input  logic signed [W-1:0]    bi,
    output logic                   s2_en,
    output logic [$clog2(N)-2:0]   idx_o,
    output logic signed [W-1:0]    y0r,
    output logic signed [W-1:0]    y0i,
    output logic signed [W-1:0]    y1r,
    output logic signed [W-1:0]    y1i
);

    logic [3:0] en_sr;

    logic signed [W-1:0] a1r, a1i, b1r, b1i;
    logic signed [W-1:0] wr, wi;
    logic signed [W-1:0] a2r, a2i;
    logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [W-1:0] a3r, a3i;
    logic signed [W:0] tr, ti;

    logic signed [W:0]   tr_n, ti_n;
    logic signed [W+1:0] s0r, s0i, s1r, s1i;
    logic signed [W-1:0] y0r_n, y0i_n, y1r_n, y1i_n;

    fft_twiddle_rom #(.N(N)) u_rom (
        .clk (clk),
        .rst (rst),
        .k   (idx),
        .wr  (wr),
        .wi  (wi)
    );

    // Enable shift register: a pair's valid bit travels alongside its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sr <= '0;
        end else begin
            en_sr <= {en_sr[2:0], s1_en};
        end
    end

    assign s2_en = en_sr[3];

    // Output pair counter, advancing once per emitted pair and wrapping at N/2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_o <= '0;
        end else if (s2_en) begin
            idx_o <= idx_o + 1'b1;
        end
    end

    // Rounded, rescaled complex product b*W, held at W+1 bits.
    always_comb begin
        tr_n = (W+1)'(((2*W+1)'(p_rr) - (2*W+1)'(p_ii) + (2*W+1)'(RND)) >>> TF);
        ti_n = (W+1)'(((2*W+1)'(p_ri) + (2*W+1)'(p_ir) + (2*W+1)'(RND)) >>> TF);
    end

    // Butterfly sum/difference at W+2 bits followed by width reduction.
    always_comb begin
        s0r = (W+2)'(a3r) + (W+2)'(tr);
        s0i = (W+2)'(a3i) + (W+2)'(ti);
        s1r = (W+2)'(a3r) - (W+2)'(tr);
        s1i = (W+2)'(a3i) - (W+2)'(ti);
`ifdef FFT_BFLY_SCALE_EN
        y0r_n = sat(s0r >>> 1);
        y0i_n = sat(s0i >>> 1);
        y1r_n = sat(s1r >>> 1);
        y1i_n = sat(s1i >>> 1);
`else
        y0r_n = sat(s0r);
        y0i_n = sat(s0i);
        y1r_n = sat(s1r);
        y1i_n = sat(s1i);
`endif
    end

    // Data pipeline advances every cycle; bubbles simply carry don't-care data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1r  <= '0;
            a1i  <= '0;
            b1r  <= '0;
            b1i  <= '0;
            a2r  <= '0;
            a2i  <= '0;
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
            a3r  <= '0;
            a3i  <= '0;
            tr   <= '0;
            ti   <= '0;
            y0r  <= '0;
            y0i  <= '0;
            y1r  <= '0;
            y1i  <= '0;
        end else begin
            a1r  <= ar;
            a1i  <= ai;
            b1r  <= br;
            b1i  <= bi;
            a2r  <= a1r;
            a2i  <= a1i;
            p_rr <= b1r * wr;
            p_ii <= b1i * wi;
            p_ri <= b1r * wi;
            p_ir <= b1i * wr;
            a3r  <= a2r;
            a3i  <= a2i;
            tr   <= tr_n;
            ti   <= ti_n;
            y0r  <= y0r_n;
            y0i  <= y0i_n;
            y1r  <= y1r_n;
            y1i  <= y1i_n;
        end
    end

endmodule

// File: tb/tb_fft_bfly_s2.sv
// Testbench for fft_bfly_s2 (N=8, W=16): table-driven vectors plus
// random traffic checked through a scoreboard, gap-pattern and
// in-flight reset sequences. Honors FFT_BFLY_SCALE_EN like the design.
module tb_fft_bfly_s2;
    import fft_bfly_s2_pkg::*;

    typedef struct {
        int k;
        int ar, ai, br, bi;
        int e0r, e0i, e1r, e1i;
    } vec_t;

    typedef struct {
        int e0r, e0i, e1r, e1i;
        int tag;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                s1_en;
    logic [1:0]          idx;
    logic signed [W-1:0] ar, ai, br, bi;
    logic                s2_en;
    logic [1:0]          idx_o;
    logic signed [W-1:0] y0r, y0i, y1r, y1i;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   exp_idx    = 0;
    exp_t sb[$];

    int tw_re[4] = '{16384, 11585, 0, -11585};
    int tw_im[4] = '{0, -11585, -16384, -11585};

    fft_bfly_s2 #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .s1_en (s1_en),
        .idx   (idx),
        .ar    (ar),
        .ai    (ai),
        .br    (br),
        .bi    (bi),
        .s2_en (s2_en),
        .idx_o (idx_o),
        .y0r   (y0r),
        .y0i   (y0i),
        .y1r   (y1r),
        .y1i   (y1i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clip(input longint v);
        longint r;
`ifdef FFT_BFLY_SCALE_EN
        r = v >>> 1;
`else
        r = v;
`endif
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic exp_t model(input int k, input int a_r, input int a_i,
                                   input int b_r, input int b_i);
        exp_t   e;
        longint t_r, t_i;
        t_r = (longint'(b_r) * tw_re[k] - longint'(b_i) * tw_im[k] + 8192) >>> 14;
        t_i = (longint'(b_r) * tw_im[k] + longint'(b_i) * tw_re[k] + 8192) >>> 14;
        e.e0r = clip(a_r + t_r);
        e.e0i = clip(a_i + t_i);
        e.e1r = clip(a_r - t_r);
        e.e1i = clip(a_i - t_i);
        e.tag = 0;
        return e;
    endfunction

    task automatic driveRaw(input int k, input int a_r, input int a_i,
                            input int b_r, input int b_i);
        @(negedge clk);
        s1_en = 1'b1;
        idx   = 2'(k);
        ar    = 16'(a_r);
        ai    = 16'(a_i);
        br    = 16'(b_r);
        bi    = 16'(b_i);
    endtask

    // Drive one pair with expected results taken from a table record.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        driveRaw(v.k, v.ar, v.ai, v.br, v.bi);
        e.e0r = v.e0r;
        e.e0i = v.e0i;
        e.e1r = v.e1r;
        e.e1i = v.e1i;
        e.tag = cyc;
        sb.push_back(e);
    endtask

    task automatic applyModel(input int k, input int a_r, input int a_i,
                              input int b_r, input int b_i);
        exp_t e;
        driveRaw(k, a_r, a_i, b_r, b_i);
        e     = model(k, a_r, a_i, b_r, b_i);
        e.tag = cyc;
        sb.push_back(e);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        s1_en = 1'b0;
        idx   = 2'($urandom_range(0, 3));
        ar    = 16'($urandom);
        ai    = 16'($urandom);
        br    = 16'($urandom);
        bi    = 16'($urandom);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Output monitor: each pair must appear exactly 4 cycles after it was driven.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            exp_idx = 0;
        end else if (sb.size() > 0 && sb[0].tag + 4 == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("s2_en_due", int'(s2_en), 1);
            if (s2_en) begin
                checkOutput("y0r", int'(y0r), e.e0r);
                checkOutput("y0i", int'(y0i), e.e0i);
                checkOutput("y1r", int'(y1r), e.e1r);
                checkOutput("y1i", int'(y1i), e.e1i);
                checkOutput("idx_o", int'(idx_o), exp_idx);
                exp_idx = (exp_idx + 1) % 4;
            end
        end else begin
            checkOutput("s2_en_idle", int'(s2_en), 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vt[5];
        int   pat[5] = '{1, 0, 1, 1, 0};

`ifdef FFT_BFLY_SCALE_EN
        vt[0] = '{0, 1000, 0, 200, 0, 600, 0, 400, 0};
        vt[1] = '{2, 1000, 0, 100, 0, 500, -50, 500, 50};
        vt[2] = '{1, 0, 0, 1000, 0, 353, -354, -354, 353};
        vt[3] = '{0, 32767, 0, 32767, 0, 32767, 0, 0, 0};
        vt[4] = '{0, -32768, 0, -32768, 0, -32768, 0, 0, 0};
`else
        vt[0] = '{0, 1000, 0, 200, 0, 1200, 0, 800, 0};
        vt[1] = '{2, 1000, 0, 100, 0, 1000, -100, 1000, 100};
        vt[2] = '{1, 0, 0, 1000, 0, 707, -707, -707, 707};
        vt[3] = '{0, 32767, 0, 32767, 0, 32767, 0, 0, 0};
        vt[4] = '{0, -32768, 0, -32768, 0, -32768, 0, 0, 0};
`endif

        rst   = 1'b1;
        s1_en = 1'b0;
        idx   = '0;
        ar    = '0;
        ai    = '0;
        br    = '0;
        bi    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_s2_en", int'(s2_en), 0);
        checkOutput("reset_idx_o", int'(idx_o), 0);
        checkOutput("reset_y0r", int'(y0r), 0);
        checkOutput("reset_y1i", int'(y1i), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 5; i++) applyStimulus(vt[i]);

        $display("[TB] random traffic with gaps");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) idleCycle();
            applyModel(int'($urandom_range(0, 3)), rnd16(), rnd16(), rnd16(), rnd16());
        end
        repeat (6) idleCycle();

        $display("[TB] reset with pairs in flight");
        for (int i = 0; i < 3; i++) applyModel(i, rnd16(), rnd16(), rnd16(), rnd16());
        @(negedge clk);
        s1_en = 1'b0;
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("rst_s2_en", int'(s2_en), 0);
        checkOutput("rst_idx_o", int'(idx_o), 0);
        checkOutput("rst_y0r", int'(y0r), 0);
        checkOutput("rst_y0i", int'(y0i), 0);
        checkOutput("rst_y1r", int'(y1r), 0);
        checkOutput("rst_y1i", int'(y1i), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) idleCycle();

        $display("[TB] enable gap pattern 1,0,1,1,0");
        for (int i = 0; i < 5; i++) begin
            if (pat[i] == 1) applyStimulus(vt[i % 3]);
            else idleCycle();
        end
        repeat (8) idleCycle();

        checkOutput("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
